cdf_fetch: RTL

- Read-side front end of the CDF pipeline; the counterpart of the store stage, which writes 128-bit words to pixel memory.
- Walks a block of 128-bit memory words from a base address and issues reads with a fixed memory read latency.
- Unpacks each word into sixteen 8-bit pixels and streams them one per cycle into the histogram/CDF stages.
- Honours a downstream stall and prefetches the next word so unstalled streaming has no bubbles.

---
 rtl/cdf_fetch.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/cdf_fetch.sv
// cdf_fetch: read-side front end of the CDF pipeline.
// Walks a block of 128-bit words starting at a base address, one read per word
// with a fixed read latency. Each word is unpacked into sixteen 8-bit pixels
// that stream out one per cycle under a downstream stall. The next word is
// prefetched into a second buffer so that unstalled streaming has no gaps.
//
// Build option: define CDF_FETCH_MSB_FIRST_EN to unpack the most significant
// byte first. Timing is the same in both builds.
module cdf_fetch #(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              StartIn,
    input  logic [ADDR_W-1:0] BaseAddress,
    input  logic [15:0]       WordCount,
    input  logic              StallIn,
    input  logic [127:0]      ReadBus,
    output logic [ADDR_W-1:0] ReadAddress,
    output logic              ReadEnable,
    output logic [7:0]        PixelOut,
    output logic              PixelValid,
    output logic [19:0]       PixelIndex,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FETCH  = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    // Countdown value loaded when a read strobe goes out; zero marks the
    // cycle in which ReadBus carries the returned word.
    localparam logic [2:0]        LAT_LAST = 3'(READ_LATENCY - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]   state_r;
    logic [127:0] cur_buf_r;
    logic [127:0] next_buf_r;
    logic         next_full_r;
    logic [3:0]   idx_r;
    logic [15:0]  req_left_r;
    logic         rd_pending_r;
    logic [2:0]   lat_cnt_r;

    logic         accept_s;
    logic         accept_last_s;
    logic         land_s;
    logic         start_job_s;
    logic         start_zero_s;
    logic         word_start_s;
    logic         issue_s;
    logic         swap_s;
    logic         load_next_s;
    logic         finish_s;
    logic [127:0] new_word_s;

    // Pick pixel i out of a 128-bit word in the configured unpack order.
    function automatic logic [7:0] sel_byte(input logic [127:0] w, input logic [3:0] i);
`ifdef CDF_FETCH_MSB_FIRST_EN
        sel_byte = w[{~i, 3'b000} +: 8];
`else
        sel_byte = w[{i, 3'b000} +: 8];
`endif
    endfunction

    // Per-cycle decode of acceptance, read return and word transitions.
    always_comb begin
        accept_s      = PixelValid & ~StallIn;
        accept_last_s = accept_s & (idx_r == 4'd15);
        land_s        = rd_pending_r & (lat_cnt_r == 3'd0);
        start_job_s   = (state_r == IDLE) & StartIn & (WordCount != 16'd0);
        start_zero_s  = (state_r == IDLE) & StartIn & (WordCount == 16'd0);
        swap_s        = (state_r == STREAM) & accept_last_s & next_full_r;
        // A return is parked in the next buffer only while the current word
        // is still being streamed; otherwise it goes straight to current.
        load_next_s   = (state_r == STREAM) & land_s & PixelValid & ~accept_last_s;
        finish_s      = (state_r == STREAM) & accept_last_s & ~next_full_r & ~rd_pending_r;
        case (state_r)
            FETCH:   word_start_s = land_s;
            STREAM:  word_start_s = (accept_last_s & (next_full_r | land_s)) |
                                    (~PixelValid & land_s);
            default: word_start_s = 1'b0;
        endcase
        issue_s = word_start_s & (req_left_r != 16'd0);
        if (swap_s) begin
            new_word_s = next_buf_r;
        end else begin
            new_word_s = ReadBus;
        end
    end

    // Track the single outstanding read and count down its latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_pending_r <= 1'b0;
            lat_cnt_r    <= 3'd0;
        end else if (ReadEnable) begin
            rd_pending_r <= 1'b1;
            lat_cnt_r    <= LAT_LAST;
        end else if (land_s) begin
            rd_pending_r <= 1'b0;
            lat_cnt_r    <= 3'd0;
        end else if (rd_pending_r) begin
            lat_cnt_r <= lat_cnt_r - 3'd1;
        end
    end

    // Issue the first read on job start and one prefetch per new word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ReadEnable  <= 1'b0;
            ReadAddress <= '0;
            req_left_r  <= 16'd0;
        end else begin
            ReadEnable <= 1'b0;
            if (start_job_s) begin
                ReadEnable  <= 1'b1;
                ReadAddress <= BaseAddress;
                req_left_r  <= WordCount - 16'd1;
            end else if (issue_s) begin
                ReadEnable  <= 1'b1;
                ReadAddress <= ReadAddress + ADDR_ONE;
                req_left_r  <= req_left_r - 16'd1;
            end
        end
    end

    // Job-level state machine with busy and the one-cycle done pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_zero_s) begin
                        state_r <= FINISH;
                        done    <= 1'b1;
                    end else if (start_job_s) begin
                        state_r <= FETCH;
                        busy    <= 1'b1;
                    end
                end
                FETCH: begin
                    if (land_s) begin
                        state_r <= STREAM;
                    end
                end
                STREAM: begin
                    if (finish_s) begin
                        state_r <= FINISH;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                FINISH: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Prefetch buffer: filled by an early return, drained at a word boundary.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            next_buf_r  <= 128'd0;
            next_full_r <= 1'b0;
        end else if (start_job_s) begin
            next_full_r <= 1'b0;
        end else if (load_next_s) begin
            next_buf_r  <= ReadBus;
            next_full_r <= 1'b1;
        end else if (swap_s) begin
            next_full_r <= 1'b0;
        end
    end

    // Job-wide pixel ordinal, advancing once per accepted pixel.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            PixelIndex <= 20'd0;
        end else if (start_job_s) begin
            PixelIndex <= 20'd0;
        end else if (accept_s) begin
            PixelIndex <= PixelIndex + 20'd1;
        end
    end

    // Current word, byte pointer and the registered pixel output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_buf_r  <= 128'd0;
            idx_r      <= 4'd0;
            PixelOut   <= 8'd0;
            PixelValid <= 1'b0;
        end else if (start_job_s) begin
            idx_r      <= 4'd0;
            PixelValid <= 1'b0;
        end else if (word_start_s) begin
            cur_buf_r  <= new_word_s;
            idx_r      <= 4'd0;
            PixelOut   <= sel_byte(new_word_s, 4'd0);
            PixelValid <= 1'b1;
        end else if (accept_s && (idx_r != 4'd15)) begin
            idx_r    <= idx_r + 4'd1;
            PixelOut <= sel_byte(cur_buf_r, idx_r + 4'd1);
        end else if (accept_last_s) begin
            // Last byte taken with no data ready: bubble until the read
            // lands, or the job ends here.
            PixelValid <= 1'b0;
        end
    end

endmodule
